// File: rtl/result_pack_fifo_if.sv
// Stream bundle for result_pack_fifo.
//   s_tdata / s_tvalid / s_tlast : sample stream from the pipeline. It has no
//                                  ready, so every cycle with s_tvalid=1 delivers
//                                  one sample that must be taken.
//   m_tdata / m_tkeep / m_tvalid / m_tready / m_tlast : packed beat stream to S2MM.
// Handshake on the m_ side: a beat transfers on a rising edge where
// m_tvalid && m_tready. Once m_tvalid is high, it and m_tdata/m_tkeep/m_tlast
// hold steady until that transfer happens. m_tvalid never depends on m_tready.
// Modports: slave = the packing block, master = the side that drives samples
// and consumes beats.
interface result_pack_fifo_if #(
    parameter int IN_WIDTH = 64,
    parameter int SAMPLE_W = 32,
    parameter int PACK     = 2
);
    localparam int DATA_W = PACK * SAMPLE_W;
    localparam int KEEP_W = DATA_W / 8;

    logic [IN_WIDTH-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tlast;
    logic [DATA_W-1:0]   m_tdata;
    logic [KEEP_W-1:0]   m_tkeep;
    logic                m_tvalid;
    logic                m_tready;
    logic                m_tlast;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output m_tdata, m_tkeep, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  m_tdata, m_tkeep, m_tvalid, m_tlast
    );
endinterface

// File: rtl/result_pack_fifo.sv
// result_pack_fifo: packs PACK signed samples from a non-stallable pipeline
// into one output beat and buffers beats in a first-word-fall-through FIFO
// towards a DMA S2MM slave that may apply backpressure.
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   bus            result_pack_fifo_if.slave (s_* samples in, m_* beats out)
//   clear_stat     sync pulse clearing overflow, drop_count, frame_count
//   overflow       sticky flag: a beat was dropped because the FIFO was full
//   drop_count     dropped beats, saturating
//   frame_count    frames (tlast beats) accepted into the FIFO, wrapping
//   fifo_level     beats currently stored
module result_pack_fifo #(
    parameter int IN_WIDTH   = 64,
    parameter int SAMPLE_W   = 32,
    parameter int PACK       = 2,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    result_pack_fifo_if.slave             bus,
    input  logic                          clear_stat,
    output logic                          overflow,
    output logic [CNT_W-1:0]              drop_count,
    output logic [CNT_W-1:0]              frame_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DATA_W  = PACK * SAMPLE_W;
    localparam int KEEP_W  = DATA_W / 8;
    localparam int LANE_KW = SAMPLE_W / 8;
    localparam int SLOT_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BEAT_W  = 1 + KEEP_W + DATA_W;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PACK - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [AW:0]       PTR_ONE   = (AW + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Only the low SAMPLE_W bits of s_tdata carry the sample.
    logic unused_hi;
    assign unused_hi = ^bus.s_tdata;

    // ------------------------------------------------------------------
    // Pack stage
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0]   slot;
    logic [SAMPLE_W-1:0] lanes [PACK];
    logic [SAMPLE_W-1:0] sample;
    logic                beat_done;
    logic [DATA_W-1:0]   beat_data;
    logic [KEEP_W-1:0]   beat_keep;

    assign sample    = bus.s_tdata[SAMPLE_W-1:0];
    assign beat_done = bus.s_tvalid && ((slot == SLOT_LAST) || bus.s_tlast);

    // The completing sample bypasses the lane buffer so the beat can be
    // pushed on the same edge; lanes above the current slot are zero-padded.
    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            if (SLOT_W'(i) < slot) begin
                beat_data[i*SAMPLE_W +: SAMPLE_W] = lanes[i];
                beat_keep[i*LANE_KW +: LANE_KW]   = '1;
            end else if (SLOT_W'(i) == slot) begin
                beat_data[i*SAMPLE_W +: SAMPLE_W] = sample;
                beat_keep[i*LANE_KW +: LANE_KW]   = '1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            slot <= '0;
            for (int i = 0; i < PACK; i++) begin
                lanes[i] <= '0;
            end
        end else if (bus.s_tvalid) begin
            lanes[slot] <= sample;
            slot        <= beat_done ? '0 : slot + SLOT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Beat FIFO (first-word fall-through, wrap-bit pointers)
    // ------------------------------------------------------------------
    logic [BEAT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [BEAT_W-1:0] rd_beat;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && bus.m_tready;
    // A simultaneous pop frees the slot being written, so a full FIFO
    // still accepts the beat in that cycle.
    assign push_ok = beat_done && (!full || pop);
    assign drop    = beat_done && full && !pop;

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {bus.s_tlast, beat_keep, beat_data};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Head entry is shown combinationally; forced to zero while empty so
    // the outputs read 0 after reset regardless of stale memory contents.
    assign rd_beat      = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.m_tvalid = !empty;
    assign bus.m_tlast  = rd_beat[BEAT_W-1];
    assign bus.m_tkeep  = rd_beat[DATA_W +: KEEP_W];
    assign bus.m_tdata  = rd_beat[DATA_W-1:0];
    assign fifo_level   = wr_ptr - rd_ptr;

    // ------------------------------------------------------------------
    // Statistics; a clear in the same cycle as an event takes priority.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow    <= 1'b0;
            drop_count  <= '0;
            frame_count <= '0;
        end else if (clear_stat) begin
            overflow    <= 1'b0;
            drop_count  <= '0;
            frame_count <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_ONE;
                end
            end
            if (push_ok && bus.s_tlast) begin
                frame_count <= frame_count + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_result_pack_fifo.sv
// Testbench for result_pack_fifo (PACK=2, SAMPLE_W=32, FIFO_DEPTH=64).
module tb_result_pack_fifo;
    localparam int IN_WIDTH = 64;
    localparam int SW       = 32;
    localparam int PACK     = 2;
    localparam int DEPTH    = 64;
    localparam int CNT_W    = 16;
    localparam int DW       = PACK * SW;
    localparam int KW       = DW / 8;
    localparam int BW       = 1 + KW + DW;

    logic             aclk;
    logic             aresetn;
    logic             clear_stat;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] frame_count;
    logic [6:0]       fifo_level;

    result_pack_fifo_if #(.IN_WIDTH(IN_WIDTH), .SAMPLE_W(SW), .PACK(PACK)) bus ();

    result_pack_fifo #(
        .IN_WIDTH(IN_WIDTH), .SAMPLE_W(SW), .PACK(PACK),
        .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus),
        .clear_stat(clear_stat),
        .overflow(overflow),
        .drop_count(drop_count),
        .frame_count(frame_count),
        .fifo_level(fifo_level)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- scoreboard / model state ----------------
    logic [BW-1:0]    exp_q[$];
    logic [SW-1:0]    m_lanes [PACK];
    int               m_slot;
    bit               exp_ovf;
    logic [CNT_W-1:0] exp_drop;
    logic [CNT_W-1:0] exp_frames;
    int               n_tests;
    int               n_fail;

    task automatic model_reset();
        exp_q.delete();
        m_slot     = 0;
        exp_ovf    = 1'b0;
        exp_drop   = '0;
        exp_frames = '0;
    endtask

    // One clock cycle, entered and left on a falling edge. Drives inputs,
    // checks the head beat if it is being consumed, and advances the model
    // on the rising edge.
    task automatic step(input bit v, input logic [SW-1:0] d, input bit l,
                        input bit rdy, input bit clr);
        logic [BW-1:0] beat;
        logic [DW-1:0] bd;
        logic [KW-1:0] bk;
        bit            done;
        bit            pop;
        bus.s_tvalid   = v;
        bus.s_tdata    = {32'($urandom), d};
        bus.s_tlast    = l;
        bus.m_tready   = rdy;
        clear_stat     = clr;
        n_tests++;
        if (bus.m_tvalid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL m_tvalid: got %b expected %b", bus.m_tvalid, exp_q.size() != 0);
        end
        if (rdy && exp_q.size() > 0) begin
            n_tests++;
            if ({bus.m_tlast, bus.m_tkeep, bus.m_tdata} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL pop_beat: got last=%b keep=%h data=%h expected last=%b keep=%h data=%h",
                         bus.m_tlast, bus.m_tkeep, bus.m_tdata,
                         exp_q[0][BW-1], exp_q[0][DW +: KW], exp_q[0][DW-1:0]);
            end
        end
        done = 1'b0;
        beat = '0;
        if (v) begin
            m_lanes[m_slot] = d;
            if (m_slot == PACK - 1 || l) begin
                bd = '0;
                bk = '0;
                for (int i = 0; i <= m_slot; i++) begin
                    bd[i*SW +: SW] = m_lanes[i];
                    bk[i*4 +: 4]   = 4'hF;
                end
                beat   = {l, bk, bd};
                done   = 1'b1;
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
        pop = rdy && (exp_q.size() > 0);
        @(posedge aclk);
        if (pop) void'(exp_q.pop_front());
        if (done) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(beat);
                if (l) exp_frames = exp_frames + 1'b1;
            end else begin
                exp_ovf = 1'b1;
                if (exp_drop != '1) exp_drop = exp_drop + 1'b1;
            end
        end
        if (clr) begin
            exp_ovf    = 1'b0;
            exp_drop   = '0;
            exp_frames = '0;
        end
        @(negedge aclk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step(0, '0, 0, 1, 0);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
        end
        step(0, '0, 0, 1, 0);
        n_tests++;
        if (fifo_level !== 7'd0 || bus.m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: level=%0d valid=%b expected 0/0", fifo_level, bus.m_tvalid);
        end
    endtask

    task automatic fresh();
        drain();
        step(0, '0, 0, 1, 1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        n_tests++;
        if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== '0 || bus.m_tkeep !== '0 || bus.m_tlast !== 1'b0 ||
            fifo_level !== 7'd0 || overflow !== 1'b0 || drop_count !== '0 || frame_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h keep=%h last=%b level=%0d ovf=%b drop=%0d frames=%0d expected all 0",
                     bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast, fifo_level, overflow, drop_count, frame_count);
        end
        aresetn = 1'b1;
        model_reset();
        step(0, '0, 0, 0, 0);
        // 3 beats queued (frame closed on the third), then a partial beat
        for (int i = 0; i < 6; i++) step(1, 32'h100 + i, i == 5, 0, 0);
        step(1, 32'h1FF, 0, 0, 0);
        n_tests++;
        if (fifo_level !== 7'd3 || frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL pre_reset_level: level=%0d frames=%0d expected 3/1", fifo_level, frame_count);
        end
        aresetn = 1'b0;
        #1;
        n_tests++;
        if (bus.m_tvalid !== 1'b0 || fifo_level !== 7'd0 || frame_count !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: valid=%b level=%0d frames=%0d expected 0/0/0",
                     bus.m_tvalid, fifo_level, frame_count);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
        // partial beat discarded: a lone last sample must land in lane 0
        step(1, 32'h55, 1, 0, 0);
        n_tests++;
        if (bus.m_tdata !== 64'h0000_0000_0000_0055 || bus.m_tkeep !== 8'h0F || bus.m_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL lane0_after_reset: data=%h keep=%h last=%b expected 0000000000000055/0f/1",
                     bus.m_tdata, bus.m_tkeep, bus.m_tlast);
        end
        fresh();
    endtask

    task automatic test_pack();
        step(1, 32'h11, 0, 1, 0);
        n_tests++;
        if (bus.m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_no_early_beat: valid=%b expected 0", bus.m_tvalid);
        end
        step(1, 32'h22, 0, 1, 0);
        n_tests++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 64'h0000_0022_0000_0011 ||
            bus.m_tkeep !== 8'hFF || bus.m_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_beat0: valid=%b data=%h keep=%h last=%b expected 1/0000002200000011/ff/0",
                     bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast);
        end
        step(1, 32'h33, 0, 1, 0);
        step(1, 32'h44, 1, 1, 0);
        n_tests++;
        if (bus.m_tdata !== 64'h0000_0044_0000_0033 || bus.m_tkeep !== 8'hFF ||
            bus.m_tlast !== 1'b1 || frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL pack_beat1: data=%h keep=%h last=%b frames=%0d expected 0000004400000033/ff/1/1",
                     bus.m_tdata, bus.m_tkeep, bus.m_tlast, frame_count);
        end
        fresh();
    endtask

    task automatic test_odd_tail();
        step(1, 32'hA, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0);
        step(1, 32'hC, 1, 0, 0);
        step(0, '0, 0, 1, 0);
        n_tests++;
        if (bus.m_tdata !== 64'h0000_0000_0000_000C || bus.m_tkeep !== 8'h0F || bus.m_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_tail: data=%h keep=%h last=%b expected 000000000000000c/0f/1",
                     bus.m_tdata, bus.m_tkeep, bus.m_tlast);
        end
        fresh();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 2 * (DEPTH + 3); i++) step(1, 32'h1000 + i, 0, 0, 0);
        n_tests++;
        if (fifo_level !== 7'd64 || drop_count !== 16'd3 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_stats: level=%0d drop=%0d ovf=%b expected 64/3/1",
                     fifo_level, drop_count, overflow);
        end
        drain();
        step(0, '0, 0, 1, 1);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 2 * DEPTH; i++) step(1, 32'h2000 + i, 0, 0, 0);
        step(1, 32'h2AAA, 0, 0, 0);
        step(1, 32'h2BBB, 1, 1, 0);
        n_tests++;
        if (fifo_level !== 7'd64 || drop_count !== 16'd0 || overflow !== 1'b0 || frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL full_pop: level=%0d drop=%0d ovf=%b frames=%0d expected 64/0/0/1",
                     fifo_level, drop_count, overflow, frame_count);
        end
        fresh();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 2 * DEPTH; i++) step(1, 32'h3000 + i, i == 2 * DEPTH - 1, 0, 0);
        step(1, 32'h3E00, 0, 0, 0);
        step(1, 32'h3E01, 0, 0, 0);
        n_tests++;
        if (overflow !== 1'b1 || drop_count !== 16'd1 || frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL pre_clear: ovf=%b drop=%0d frames=%0d expected 1/1/1", overflow, drop_count, frame_count);
        end
        step(1, 32'h3F00, 0, 0, 0);
        step(1, 32'h3F01, 1, 0, 1);
        n_tests++;
        if (overflow !== 1'b0 || drop_count !== '0 || frame_count !== '0 || fifo_level !== 7'd64) begin
            n_fail++;
            $display("FAIL clear_wins: ovf=%b drop=%0d frames=%0d level=%0d expected 0/0/0/64",
                     overflow, drop_count, frame_count, fifo_level);
        end
        fresh();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0,
                 (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), 0);
            if (i % 50 == 49) begin
                n_tests++;
                if (fifo_level !== 7'(exp_q.size()) || overflow !== exp_ovf ||
                    drop_count !== exp_drop || frame_count !== exp_frames) begin
                    n_fail++;
                    $display("FAIL random_state: level=%0d ovf=%b drop=%0d frames=%0d expected %0d/%b/%0d/%0d",
                             fifo_level, overflow, drop_count, frame_count,
                             exp_q.size(), exp_ovf, exp_drop, exp_frames);
                end
            end
        end
        drain();
        n_tests++;
        if (frame_count !== exp_frames || drop_count !== exp_drop) begin
            n_fail++;
            $display("FAIL random_final: frames=%0d drop=%0d expected %0d/%0d",
                     frame_count, drop_count, exp_frames, exp_drop);
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b0;
        clear_stat   = 1'b0;
        model_reset();
        @(negedge aclk);
        test_reset();
        test_pack();
        test_odd_tail();
        test_backpressure();
        test_full_pop();
        test_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
